lsu: RTL and testbench

Load/store unit that sits between the core's execute stage and the word-organised data memory. It accepts one RV32I load or store per handshake, generates byte-lane write enables and lane-replicated store data, issues the access to the data memory, and returns sign- or zero-extended load data. It absorbs the memory's one-cycle synchronous read latency and flags illegal or misaligned accesses.

---
 rtl/lsu_if.sv | 27 ++
 rtl/lsu.sv | 152 +++++++++++++++
 tb/tb_lsu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The LSU connects through the slave modport; the core/memory side uses master.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_we;
   logic [31:0] mem_dout;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: byte-lane stores, extended loads, one-cycle memory read latency.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses; otherwise they are force-aligned.
module lsu (
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        f3_ok;
   logic        misal;
   logic        reject;
   logic [31:0] eff_addr;
   logic [3:0]  lanes;

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                            input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_din    = din_q;

   always_comb begin
      if (bus.req_we)
         f3_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
      else
         f3_ok = (bus.req_funct3 != 3'b011) && (bus.req_funct3[2:1] != 2'b11);
      misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      eff_addr = bus.req_addr;
      if (bus.req_funct3[1:0] == 2'b01) eff_addr[0]   = 1'b0;
      if (bus.req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      reject = !f3_ok || misal;
`else
      reject = !f3_ok;
`endif
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d  = bus.req_we;
               f3_d  = bus.req_funct3;
               off_d = eff_addr[1:0];
               if (reject) begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
                  state_d = RESP;
               end else begin
                  addr_d = eff_addr;
                  if (bus.req_we) din_d = store_rep(bus.req_funct3[1:0], bus.req_wdata);
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               err_d   = 1'b0;
               rdata_d = 32'd0;
               state_d = RESP;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // mem_dout carries the word addressed during ISSUE
            rdata_d = load_ext(f3_q, bus.mem_dout, off_q);
            err_d   = 1'b0;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (f3_q[1:0])
         2'b00:   lanes = 4'b0001 << off_q;
         2'b01:   lanes = 4'b0011 << off_q;
         default: lanes = 4'b1111;
      endcase
   end

   // Gated by rst so an ISSUE edge that coincides with reset never writes
   assign bus.mem_we = (state_q == ISSUE && we_q && !rst) ? lanes : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         addr_q  <= 32'd0;
         din_q   <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a synchronous-read word memory model.
module tb_lsu;
   logic clk;
   logic rst;
   lsu_if bus ();

   lsu dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int we_cnt = 0;
   int resp_cnt = 0;
   logic [3:0]  last_we;
   logic [31:0] last_din;
   logic [31:0] last_addr;
   logic [31:0] mem [0:1023];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: registered read, byte-lane writes
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++)
         if (bus.mem_we[n]) mem[bus.mem_addr[11:2]][8*n +: 8] <= bus.mem_din[8*n +: 8];
      bus.mem_dout <= mem[bus.mem_addr[11:2]];
   end

   always @(negedge clk) begin
      if (bus.mem_we != 4'b0000) begin
         we_cnt    <= we_cnt + 1;
         last_we   <= bus.mem_we;
         last_din  <= bus.mem_din;
         last_addr <= bus.mem_addr;
      end
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                       output logic err, input string tag);
      @(negedge clk);
      check({tag, "_ready_in"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = -1;
      for (int k = 0; k < 8; k++) begin
         if (bus.resp_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, {31'd0, bus.resp_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
   endtask

   task automatic step(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int e_lat, input logic [31:0] e_rdata, input logic e_err,
                       input int e_wes, input logic [3:0] e_we, input logic [31:0] e_din,
                       input logic [31:0] e_maddr);
      int          w0;
      int          lat;
      logic [31:0] rd;
      logic        er;
      w0 = we_cnt;
      xact(we, f3, addr, wdata, lat, rd, er, tag);
      check({tag, "_lat"}, lat, e_lat);
      check({tag, "_rdata"}, rd, e_rdata);
      check({tag, "_err"}, {31'd0, er}, {31'd0, e_err});
      check({tag, "_we_cycles"}, we_cnt - w0, e_wes);
      if (e_wes > 0) begin
         check({tag, "_mem_we"}, {28'd0, last_we}, {28'd0, e_we});
         check({tag, "_mem_din"}, last_din, e_din);
         check({tag, "_mem_addr"}, last_addr, e_maddr);
      end
   endtask

   initial begin
      int rc;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_err", {31'd0, bus.resp_err}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_din", bus.mem_din, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      // tag, we, f3, addr, wdata, lat, rdata, err, we_cycles, mem_we, mem_din, mem_addr
      step("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0,        1'b0, 1, 4'b1111, 32'hDEADBEEF, 32'h10);
      step("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("sb13",  1'b1, 3'b000, 32'h13, 32'h00000080, 1, 32'h0,        1'b0, 1, 4'b1000, 32'h80808080, 32'h13);
      step("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        2, 32'hFFFFFF80, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        2, 32'h00000080, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        2, 32'hFFFFFFBE, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("sh22",  1'b1, 3'b001, 32'h22, 32'h00008001, 1, 32'h0,        1'b0, 1, 4'b1100, 32'h80018001, 32'h22);
      step("lh22",  1'b0, 3'b001, 32'h22, 32'h0,        2, 32'hFFFF8001, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("lhu22", 1'b0, 3'b101, 32'h22, 32'h0,        2, 32'h00008001, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      step("lw11",  1'b0, 3'b010, 32'h11, 32'h0,        0, 32'h0,        1'b1, 0, 4'b0000, 32'h0, 32'h0);
`else
      step("lw11",  1'b0, 3'b010, 32'h11, 32'h0,        2, 32'h80ADBEEF, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
`endif
      step("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0,        0, 32'h0, 1'b1, 0, 4'b0000, 32'h0, 32'h0);
      step("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h12345678, 0, 32'h0, 1'b1, 0, 4'b0000, 32'h0, 32'h0);
      step("lw10_again", 1'b0, 3'b010, 32'h10, 32'h0,       2, 32'h80ADBEEF, 1'b0, 0, 4'b0000, 32'h0, 32'h0);
      step("sw30",  1'b1, 3'b010, 32'h30, 32'h11111111, 1, 32'h0,        1'b0, 1, 4'b1111, 32'h11111111, 32'h30);

      // Reset asserted while a store sits in ISSUE
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h30;
      bus.req_wdata  = 32'h22222222;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("rstmid_issue_we", {28'd0, bus.mem_we}, 32'hF);
      rc = resp_cnt;
      #1;
      rst = 1'b1;
      #1;
      check("rstmid_we_drop", {28'd0, bus.mem_we}, 32'd0);
      check("rstmid_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rstmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_ready_after", {31'd0, bus.req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("rstmid_no_resp", resp_cnt - rc, 32'd0);
      step("lw30",  1'b0, 3'b010, 32'h30, 32'h0,        2, 32'h11111111, 1'b0, 0, 4'b0000, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
